gpio_pin_filter22: RTL
======================

Name: gpio_pin_filter22

Overview:
- Per-pin input conditioning stage between the GPIO pads and the GPIO lite subunit's pin_in22 bus.
- Each pad is synchronised into pclk22 with two flops, then glitch-filtered: a new level is passed only after it has been stable for a programmable number of cycles.
- Emits the filtered level plus per-pin change and glitch-reject strobes for debug and interrupt statistics.

Parameters:
- WIDTH, 16: number of GPIO pins; must match the subunit pin bus width.
- CNT_W, 8: width of the stability counter and of filt_len22.

Ports:
- pclk22  input  1  system clock; all flops on rising edge.
- reset22  input  1  synchronous, active-high reset.
- pad_in22  input  WIDTH  raw asynchronous pad levels.
- filt_en22  input  WIDTH  per-pin filter enable; 0 = bypass (synchroniser only).
- filt_len22  input  CNT_W  stability threshold, shared by all pins; quasi-static but may change at any time.
- pin_in22  output  WIDTH  filtered level, registered; drives the subunit pin_in22.
- chg22  output  WIDTH  1-cycle pulse when the pin_in22 bit toggles.
- glitch22  output  WIDTH  1-cycle pulse when a pending change is abandoned before acceptance.

Behaviour:
- Clock and reset: one clock, pclk22. reset22 is synchronous and active-high, sampled on the pclk22 rising edge.
- Reset values: s1, s2, pin_in22, cnt, chg22 and glitch22 are all 0. Reset mid-count discards any pending change; there is no carry-over.
- Synchroniser, per bit i: s1[i] <= pad_in22[i]; s2[i] <= s1[i]. No filtering before s2.
- Per-bit state machine is implicit: STABLE when cnt=0 and s2=out; PENDING when s2!=out.
- Bypass (filt_en22[i]=0):
  - pin_in22[i] <= s2[i] and cnt <= 0 every cycle.
  - chg22[i] pulses on toggle.
  - glitch22[i] = 0.
  - Pad-to-pin_in22 latency is 3 cycles.
- Filter (filt_en22[i]=1), checked in this order:
  - If s2!=out and cnt >= filt_len22: out <= s2, cnt <= 0, chg22 <= 1.
  - Else if s2!=out: cnt <= cnt+1, saturating at 2^CNT_W-1 (never wraps).
  - Else (s2==out): cnt <= 0, and glitch22 <= 1 if cnt was nonzero.
- Acceptance timing: a change is accepted after filt_len22+1 consecutive mismatching s2 samples. Pad-to-output latency is filt_len22+3 cycles, so filt_len22=0 behaves like bypass.
- The >= compare means lowering filt_len22 below a running cnt accepts the change on the next mismatching cycle. Raising filt_len22 extends the wait; no wrap-around occurs.
- Toggling filt_en22[i] from 1 to 0 mid-count: the next cycle follows bypass, cnt clears, and no glitch22 pulse is generated.
- chg22 and glitch22 are registered and mutually exclusive per bit in any cycle. Both are 0 in any cycle that follows reset.
- Bits are fully independent; simultaneous events on different pins are handled in parallel.

Decomposition:
- Shared package gpio_pkg22 holds:
  - GPIO_WIDTH=16 and GPIO_FILT_CNT_W=8 defaults;
  - the GPIO_FILT_CNT_MAX constant.
- One natural sub-module: gpio_pin_filter_bit22. It covers one pin (synchroniser, counter, compare, strobes) and is instantiated WIDTH times in a generate loop.
- The top level only fans out filt_len22 and concatenates outputs.

Test Plan:
- Reset and defaults: assert reset22 with pad_in22=16'hFFFF -> pin_in22, chg22 and glitch22 are 0 during reset. After release with filt_en22=0, pin_in22=16'hFFFF exactly 3 cycles after the first non-reset edge, with chg22=16'hFFFF for one cycle.
- Threshold: filt_en22=16'h0001, filt_len22=4, pad_in22[0] rises and holds -> pin_in22[0] rises 7 cycles later, chg22[0] pulses once, glitch22[0] stays 0.
- Glitch reject: filt_len22=4, pad_in22[0] high for 3 cycles then low -> pin_in22[0] stays 0 and glitch22[0] pulses once, 3 cycles after pad returns low.
- Threshold change mid-count: filt_len22=10, pad high for 6 cycles, then filt_len22=2 -> pin_in22[0] rises on the next cycle. No counter wrap when filt_len22=8'hFF and pad is held 300 cycles (accepted at cycle 258).
- Reset mid-operation: reset22 asserted while cnt=3 on pin 5 -> after release cnt restarts from 0, and acceptance needs the full filt_len22+1 samples again.
- Independence: pins 0 and 15 toggle in the same cycle, pin 0 filtered (len 2) and pin 15 bypassed -> pin 15 changes at +3, pin 0 at +5, chg22 pulses on each separately.

Source files
------------

// File: rtl/gpio_pkg22.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg22
// Description : Shared defaults for the GPIO pad input conditioning path.
//               GPIO_WIDTH        - default number of GPIO pins
//               GPIO_FILT_CNT_W   - default width of the stability counter
//               GPIO_FILT_CNT_MAX - saturation value of a default-width counter
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg22;

    localparam int GPIO_WIDTH      = 16;
    localparam int GPIO_FILT_CNT_W = 8;

    localparam logic [GPIO_FILT_CNT_W-1:0] GPIO_FILT_CNT_MAX = {GPIO_FILT_CNT_W{1'b1}};

endpackage : gpio_pkg22
`default_nettype wire

// File: rtl/gpio_pin_filter_bit22.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_filter_bit22
// Description : One-pin input conditioner: two-flop synchroniser followed by
//               a stability-count glitch filter.
// Ports       : pclk22     in   clock, rising edge
//               reset22    in   synchronous active-high reset
//               pad_in22   in   raw asynchronous pad level
//               filt_en22  in   1 = filter, 0 = bypass (synchroniser only)
//               filt_len22 in   stability threshold (CNT_W bits)
//               pin_in22   out  filtered level, registered
//               chg22      out  1-cycle pulse when pin_in22 toggles
//               glitch22   out  1-cycle pulse when a pending change is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_filter_bit22
    import gpio_pkg22::*;
#(
    parameter int CNT_W = GPIO_FILT_CNT_W
) (
    input  logic             pclk22,
    input  logic             reset22,
    input  logic             pad_in22,
    input  logic             filt_en22,
    input  logic [CNT_W-1:0] filt_len22,
    output logic             pin_in22,
    output logic             chg22,
    output logic             glitch22
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1;
    logic             r_s2;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;
    logic             r_chg;
    logic             r_glitch;

    logic             w_mismatch;
    logic [CNT_W-1:0] w_cnt_inc;

    // PENDING whenever the synchronised level differs from the output.
    assign w_mismatch = (r_s2 != r_out);

    // Counter holds at all-ones instead of wrapping, so a raised threshold
    // can never make a long-pending change look freshly started.
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : (r_cnt + C_CNT_ONE);

    always_ff @(posedge pclk22) begin
        if (reset22) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_out    <= 1'b0;
            r_cnt    <= '0;
            r_chg    <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_s1     <= pad_in22;
            r_s2     <= r_s1;
            r_chg    <= 1'b0;
            r_glitch <= 1'b0;

            if (!filt_en22) begin
                // Bypass: follow the synchroniser; a pending count is simply
                // dropped without reporting it as a glitch.
                r_cnt <= '0;
                if (w_mismatch) begin
                    r_out <= r_s2;
                    r_chg <= 1'b1;
                end
            end else if (w_mismatch && (r_cnt >= filt_len22)) begin
                // >= so that lowering the threshold below a running count
                // accepts on the next mismatching sample.
                r_out <= r_s2;
                r_cnt <= '0;
                r_chg <= 1'b1;
            end else if (w_mismatch) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt    <= '0;
                r_glitch <= (r_cnt != '0);
            end
        end
    end

    assign pin_in22 = r_out;
    assign chg22    = r_chg;
    assign glitch22 = r_glitch;

endmodule : gpio_pin_filter_bit22
`default_nettype wire

// File: rtl/gpio_pin_filter22.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin_filter22
// Description : GPIO pad input conditioning stage: WIDTH independent
//               synchroniser + glitch-filter channels feeding pin_in22.
// Ports       : pclk22     in   clock, rising edge
//               reset22    in   synchronous active-high reset
//               pad_in22   in   raw asynchronous pad levels [WIDTH]
//               filt_en22  in   per-pin filter enable, 0 = bypass [WIDTH]
//               filt_len22 in   shared stability threshold [CNT_W]
//               pin_in22   out  filtered levels, registered [WIDTH]
//               chg22      out  per-pin toggle strobes [WIDTH]
//               glitch22   out  per-pin glitch-reject strobes [WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin_filter22
    import gpio_pkg22::*;
#(
    parameter int WIDTH = GPIO_WIDTH,
    parameter int CNT_W = GPIO_FILT_CNT_W
) (
    input  logic             pclk22,
    input  logic             reset22,
    input  logic [WIDTH-1:0] pad_in22,
    input  logic [WIDTH-1:0] filt_en22,
    input  logic [CNT_W-1:0] filt_len22,
    output logic [WIDTH-1:0] pin_in22,
    output logic [WIDTH-1:0] chg22,
    output logic [WIDTH-1:0] glitch22
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        gpio_pin_filter_bit22 #(
            .CNT_W (CNT_W)
        ) u_bit (
            .pclk22     (pclk22),
            .reset22    (reset22),
            .pad_in22   (pad_in22[gi]),
            .filt_en22  (filt_en22[gi]),
            .filt_len22 (filt_len22),
            .pin_in22   (pin_in22[gi]),
            .chg22      (chg22[gi]),
            .glitch22   (glitch22[gi])
        );
    end : g_pin

endmodule : gpio_pin_filter22
`default_nettype wire
